alu_multiciclo: RTL

Parametrised successor to the single-cycle datapath ALU. It executes logic, arithmetic, shift, compare and branch-compare operations in one cycle, and unsigned multiply and divide iteratively, one bit per cycle. A start/busy/done handshake lets the control unit stall while iterative operations run. Results and branch flags are registered and held until the next operation completes.

---
 rtl/alu_multiciclo.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/alu_multiciclo.sv
// rtl/alu_multiciclo.sv - multi-cycle ALU with iterative unsigned multiply/divide
//
// Purpose: executes logic, add/sub, shifts and signed compare in one cycle;
// unsigned multiply (shift-add, LSB first) and divide (restoring, MSB first)
// take LARGURA cycles, one bit per cycle. All outputs are registered.
//
// Ports:
//   clock                  in   clock, rising edge
//   reset_n                in   asynchronous active-low reset
//   inicio                 in   start request, sampled only while idle
//   resultado_alu_control  in   4-bit opcode, sampled with inicio
//   valor1, valor2         in   operands A and B, sampled with inicio
//   resultado_alu          out  registered result
//   resultado_desvio       out  1 for SUB/bne with valor1 != valor2
//   zero                   out  1 when resultado_alu is all zeros
//   ocupado                out  1 while an iterative op is running
//   pronto                 out  one-cycle pulse when outputs update

module alu_multiciclo #(
  parameter int LARGURA = 32,
  parameter int SHW     = $clog2(LARGURA)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               inicio,
  input  logic [3:0]         resultado_alu_control,
  input  logic [LARGURA-1:0] valor1,
  input  logic [LARGURA-1:0] valor2,
  output logic [LARGURA-1:0] resultado_alu,
  output logic               resultado_desvio,
  output logic               zero,
  output logic               ocupado,
  output logic               pronto
);

  localparam int CW = SHW + 1;
  localparam logic [CW-1:0] CNT_INI = CW'(LARGURA);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_MULU = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;

  typedef enum logic {OCIOSO, CALCULA} estado_t;

  estado_t            estado_q, estado_d;
  logic [CW-1:0]      contador_q, contador_d;
  logic               div_q, div_d;          // 1: DIVU in flight, 0: MULU
  logic [LARGURA-1:0] a_q, a_d;              // MULU: multiplicand; DIVU: dividend/quotient
  logic [LARGURA-1:0] b_q, b_d;              // MULU: multiplier;   DIVU: divisor
  logic [LARGURA-1:0] acc_q, acc_d;          // MULU: product;      DIVU: remainder
  logic [LARGURA-1:0] resultado_q, resultado_d;
  logic               desvio_q, desvio_d;
  logic               zero_q, zero_d;
  logic               ocupado_q, ocupado_d;
  logic               pronto_q, pronto_d;

  logic [SHW-1:0]     shamt;
  logic [LARGURA-1:0] res_simples;

  // Single-cycle result, straight from the inputs.
  always_comb begin
    res_simples = '0;
    shamt       = valor2[SHW-1:0];
    case (resultado_alu_control)
      OP_AND:  res_simples = valor1 & valor2;
      OP_OR:   res_simples = valor1 | valor2;
      OP_XOR:  res_simples = valor1 ^ valor2;
      OP_ADD:  res_simples = valor1 + valor2;
      OP_SUB:  res_simples = valor1 - valor2;
      OP_SLL:  res_simples = valor1 << shamt;
      OP_SRL:  res_simples = valor1 >> shamt;
      OP_SRA:  res_simples = $signed(valor1) >>> shamt;
      OP_SLT:  res_simples = {{(LARGURA-1){1'b0}}, ($signed(valor1) < $signed(valor2))};
      default: res_simples = '0;
    endcase
  end

  logic [LARGURA-1:0] mul_acc;
  logic [LARGURA-1:0] rem_low;
  logic               qbit;
  logic [LARGURA-1:0] rem_new;
  logic [LARGURA-1:0] quoc_new;
  logic [LARGURA-1:0] res_iter;

  // One iteration of shift-add multiply and restoring divide.
  // The shifted partial remainder is LARGURA+1 bits wide; when its top bit
  // (acc_q MSB) is set it exceeds any divisor, so the quotient bit is 1 and
  // the difference still fits in LARGURA bits. A zero divisor always yields
  // quotient bit 1, giving the all-ones result without special casing.
  always_comb begin
    mul_acc  = acc_q + (b_q[0] ? a_q : '0);
    rem_low  = {acc_q[LARGURA-2:0], a_q[LARGURA-1]};
    qbit     = acc_q[LARGURA-1] | (rem_low >= b_q);
    rem_new  = qbit ? (rem_low - b_q) : rem_low;
    quoc_new = {a_q[LARGURA-2:0], qbit};
    res_iter = div_q ? quoc_new : mul_acc;
  end

  always_comb begin
    estado_d    = estado_q;
    contador_d  = contador_q;
    div_d       = div_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    resultado_d = resultado_q;
    desvio_d    = desvio_q;
    zero_d      = zero_q;
    ocupado_d   = ocupado_q;
    pronto_d    = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (inicio) begin
          if (resultado_alu_control == OP_MULU || resultado_alu_control == OP_DIVU) begin
            estado_d   = CALCULA;
            contador_d = CNT_INI;
            div_d      = (resultado_alu_control == OP_DIVU);
            a_d        = valor1;
            b_d        = valor2;
            acc_d      = '0;
            ocupado_d  = 1'b1;
          end else begin
            resultado_d = res_simples;
            desvio_d    = (resultado_alu_control == OP_SUB) && (valor1 != valor2);
            zero_d      = (res_simples == '0);
            pronto_d    = 1'b1;
          end
        end
      end
      CALCULA: begin
        contador_d = contador_q - CW'(1);
        if (div_q) begin
          a_d   = quoc_new;
          acc_d = rem_new;
        end else begin
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          acc_d = mul_acc;
        end
        if (contador_q == CW'(1)) begin
          estado_d    = OCIOSO;
          resultado_d = res_iter;
          desvio_d    = 1'b0;
          zero_d      = (res_iter == '0);
          ocupado_d   = 1'b0;
          pronto_d    = 1'b1;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q    <= OCIOSO;
      contador_q  <= '0;
      div_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      resultado_q <= '0;
      desvio_q    <= 1'b0;
      zero_q      <= 1'b1;
      ocupado_q   <= 1'b0;
      pronto_q    <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      contador_q  <= contador_d;
      div_q       <= div_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      resultado_q <= resultado_d;
      desvio_q    <= desvio_d;
      zero_q      <= zero_d;
      ocupado_q   <= ocupado_d;
      pronto_q    <= pronto_d;
    end
  end

  assign resultado_alu    = resultado_q;
  assign resultado_desvio = desvio_q;
  assign zero             = zero_q;
  assign ocupado          = ocupado_q;
  assign pronto           = pronto_q;

endmodule
